// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong datapath: game states, {x,y} packing,
// and the paddle height default common to the controller and the physics engine.
package pong_pkg;

    localparam int PADDLE_HEIGHT_DEFAULT = 100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } xy_t;

    function automatic logic [31:0] pack_xy(input logic [15:0] x, input logic [15:0] y);
        xy_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    function automatic xy_t unpack_xy(input logic [31:0] v);
        return xy_t'(v);
    endfunction

    // Centre y = height/2 - paddle/2, clamped at 0 for short playfields.
    function automatic logic [15:0] centre_y(input logic [15:0] height, input logic [15:0] paddle_h);
        logic [16:0] half_h;
        logic [16:0] half_p;
        half_h = {1'b0, height} >> 1;
        half_p = {1'b0, paddle_h} >> 1;
        if (half_h > half_p) begin
            return 16'(half_h - half_p);
        end else begin
            return 16'd0;
        end
    endfunction

endpackage

// File: rtl/paddle_mover.sv
// One paddle's y register: centre load, saturating up/down step on enable.
module paddle_mover
    import pong_pkg::*;
#(
    parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEFAULT,
    parameter int PADDLE_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_centre,
    input  logic        enable,
    input  logic        up,
    input  logic        dn,
    input  logic [15:0] height,
    output logic [15:0] y
);

    localparam logic [16:0] PH   = 17'(PADDLE_HEIGHT);
    localparam logic [16:0] STEP = 17'(PADDLE_STEP);

    logic [16:0] max_y;
    logic [16:0] up_y;
    logic [16:0] dn_sum;
    logic [16:0] dn_y;
    logic [15:0] centre;
    logic [15:0] y_next;

    // Saturating step candidates and next-y selection.
    always_comb begin
        centre = centre_y(height, 16'(PADDLE_HEIGHT));
        if ({1'b0, height} >= PH) begin
            max_y = {1'b0, height} - PH;
        end else begin
            max_y = 17'd0;
        end
        if ({1'b0, y} >= STEP) begin
            up_y = {1'b0, y} - STEP;
        end else begin
            up_y = 17'd0;
        end
        dn_sum = {1'b0, y} + STEP;
        if (dn_sum > max_y) begin
            dn_y = max_y;
        end else begin
            dn_y = dn_sum;
        end
        y_next = y;
        if (load_centre) begin
            y_next = centre;
        end else if (enable && up && !dn) begin
            y_next = up_y[15:0];
        end else if (enable && dn && !up) begin
            y_next = dn_y[15:0];
        end else begin
            y_next = y;
        end
    end

    // Paddle y register; reset loads the centre from the current dimensions.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= centre;
        end else begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: serve countdown, scoring from physics miss flags, win
// detection, physics reset control and the two paddle movers.
module match_controller
    import pong_pkg::*;
#(
    parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEFAULT,
    parameter int PADDLE_STEP   = 4,
    parameter int LEFT_X        = 32,
    parameter int RIGHT_MARGIN  = 32,
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [31:0] dimensions,
    input  logic        start,
    input  logic        btn_l_up,
    input  logic        btn_l_dn,
    input  logic        btn_r_up,
    input  logic        btn_r_dn,
    input  logic [1:0]  player_did_score,
    output logic        physics_rst_n,
    output logic [31:0] left_paddle_pos,
    output logic [31:0] right_paddle_pos,
    output logic [3:0]  left_score,
    output logic [3:0]  right_score,
    output logic        game_over,
    output logic        winner
);

    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_LOAD = 16'(SERVE_FRAMES);
    localparam logic [15:0] LEFT_X16   = 16'(LEFT_X);
    localparam logic [15:0] RMARGIN16  = 16'(RIGHT_MARGIN);

    xy_t         dims;
    game_state_t state;
    game_state_t state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [3:0]  left_next;
    logic [3:0]  right_next;
    logic [3:0]  left_inc;
    logic [3:0]  right_inc;
    logic        winner_next;
    logic        recentre;
    logic        move_en;
    logic [15:0] left_y;
    logic [15:0] right_y;

    assign dims    = unpack_xy(dimensions);
    assign move_en = frame_tick && ((state == ST_SERVE) || (state == ST_PLAY));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, countdown and score logic.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        left_next   = left_score;
        right_next  = right_score;
        winner_next = winner;
        recentre    = 1'b0;
        left_inc    = left_score + 4'd1;
        right_inc   = right_score + 4'd1;
        case (state)
            ST_IDLE: begin
                recentre = 1'b1;
                if (start) begin
                    state_next = ST_SERVE;
                    cnt_next   = SERVE_LOAD;
                    left_next  = 4'd0;
                    right_next = 4'd0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt == 16'd0) begin
                        state_next = ST_PLAY;
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end else begin
                    state_next = ST_SERVE;
                end
            end
            ST_PLAY: begin
                case (player_did_score)
                    2'b01: begin
                        left_next = left_inc;
                        if (left_inc == WIN) begin
                            state_next  = ST_OVER;
                            winner_next = 1'b0;
                        end else begin
                            state_next = ST_SERVE;
                            cnt_next   = SERVE_LOAD;
                        end
                    end
                    2'b10: begin
                        right_next = right_inc;
                        if (right_inc == WIN) begin
                            state_next  = ST_OVER;
                            winner_next = 1'b1;
                        end else begin
                            state_next = ST_SERVE;
                            cnt_next   = SERVE_LOAD;
                        end
                    end
                    2'b11: begin
                        state_next = ST_SERVE;
                        cnt_next   = SERVE_LOAD;
                    end
                    default: begin
                        state_next = ST_PLAY;
                    end
                endcase
            end
            ST_OVER: begin
                if (start) begin
                    state_next = ST_SERVE;
                    cnt_next   = SERVE_LOAD;
                    left_next  = 4'd0;
                    right_next = 4'd0;
                    recentre   = 1'b1;
                end else begin
                    state_next = ST_OVER;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs; physics reset is released only in PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 16'd0;
            left_score    <= 4'd0;
            right_score   <= 4'd0;
            winner        <= 1'b0;
            physics_rst_n <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            left_score    <= left_next;
            right_score   <= right_next;
            winner        <= winner_next;
            physics_rst_n <= (state_next == ST_PLAY);
            game_over     <= (state_next == ST_OVER);
        end
    end

    paddle_mover #(
        .PADDLE_HEIGHT(PADDLE_HEIGHT),
        .PADDLE_STEP  (PADDLE_STEP)
    ) u_left (
        .clk        (clk),
        .rst        (rst),
        .load_centre(recentre),
        .enable     (move_en),
        .up         (btn_l_up),
        .dn         (btn_l_dn),
        .height     (dims.y),
        .y          (left_y)
    );

    paddle_mover #(
        .PADDLE_HEIGHT(PADDLE_HEIGHT),
        .PADDLE_STEP  (PADDLE_STEP)
    ) u_right (
        .clk        (clk),
        .rst        (rst),
        .load_centre(recentre),
        .enable     (move_en),
        .up         (btn_r_up),
        .dn         (btn_r_dn),
        .height     (dims.y),
        .y          (right_y)
    );

    assign left_paddle_pos  = pack_xy(LEFT_X16, left_y);
    assign right_paddle_pos = pack_xy(dims.x - RMARGIN16, right_y);

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller on a 640x480 field.
module tb_match_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [31:0] dimensions = {16'd640, 16'd480};
    logic        start = 1'b0;
    logic        btn_l_up = 1'b0;
    logic        btn_l_dn = 1'b0;
    logic        btn_r_up = 1'b0;
    logic        btn_r_dn = 1'b0;
    logic [1:0]  player_did_score = 2'b00;
    logic        physics_rst_n;
    logic [31:0] left_paddle_pos;
    logic [31:0] right_paddle_pos;
    logic [3:0]  left_score;
    logic [3:0]  right_score;
    logic        game_over;
    logic        winner;

    int checks = 0;
    int errors = 0;

    match_controller dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .dimensions      (dimensions),
        .start           (start),
        .btn_l_up        (btn_l_up),
        .btn_l_dn        (btn_l_dn),
        .btn_r_up        (btn_r_up),
        .btn_r_dn        (btn_r_dn),
        .player_did_score(player_did_score),
        .physics_rst_n   (physics_rst_n),
        .left_paddle_pos (left_paddle_pos),
        .right_paddle_pos(right_paddle_pos),
        .left_score      (left_score),
        .right_score     (right_score),
        .game_over       (game_over),
        .winner          (winner)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // From a freshly entered SERVE, 61 ticks are needed before PLAY.
    task automatic serve_to_play();
        for (int i = 0; i < 61; i++) ftick();
        checks++;
        if (physics_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL serve_to_play: physics_rst_n=%b expected 1", physics_rst_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (left_paddle_pos !== {16'd32, 16'd190}) begin
            errors++;
            $display("FAIL reset_left_pos: got %h expected %h", left_paddle_pos, {16'd32, 16'd190});
        end
        checks++;
        if (right_paddle_pos !== {16'd608, 16'd190}) begin
            errors++;
            $display("FAIL reset_right_pos: got %h expected %h", right_paddle_pos, {16'd608, 16'd190});
        end
        checks++;
        if ({left_score, right_score, physics_rst_n, game_over, winner} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: scores %0d/%0d prn=%b over=%b win=%b expected all 0",
                     left_score, right_score, physics_rst_n, game_over, winner);
        end
    endtask

    task automatic test_serve_countdown();
        int n;
        pulse_start();
        checks++;
        if (physics_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL serve_hold: physics_rst_n=%b expected 0", physics_rst_n);
        end
        n = 0;
        while (physics_rst_n !== 1'b1 && n < 100) begin
            ftick();
            n++;
        end
        checks++;
        if (n !== 61) begin
            errors++;
            $display("FAIL serve_countdown: released after %0d ticks expected 61", n);
        end
    endtask

    task automatic test_paddle_up();
        btn_l_up = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            ftick();
            if (i == 47) begin
                checks++;
                if (left_paddle_pos[15:0] !== 16'd2) begin
                    errors++;
                    $display("FAIL up_tick47: y=%0d expected 2", left_paddle_pos[15:0]);
                end
            end else if (i == 48) begin
                checks++;
                if (left_paddle_pos[15:0] !== 16'd0) begin
                    errors++;
                    $display("FAIL up_tick48: y=%0d expected 0", left_paddle_pos[15:0]);
                end
            end
        end
        btn_l_up = 1'b0;
        checks++;
        if (left_paddle_pos !== {16'd32, 16'd0}) begin
            errors++;
            $display("FAIL up_saturate: got %h expected %h", left_paddle_pos, {16'd32, 16'd0});
        end
    endtask

    task automatic test_paddle_down();
        btn_r_dn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (right_paddle_pos[15:0] !== 16'd190) begin
            errors++;
            $display("FAIL no_tick_no_move: y=%0d expected 190", right_paddle_pos[15:0]);
        end
        for (int i = 1; i <= 60; i++) begin
            ftick();
            if (i == 47) begin
                checks++;
                if (right_paddle_pos[15:0] !== 16'd378) begin
                    errors++;
                    $display("FAIL dn_tick47: y=%0d expected 378", right_paddle_pos[15:0]);
                end
            end
        end
        checks++;
        if (right_paddle_pos !== {16'd608, 16'd380}) begin
            errors++;
            $display("FAIL dn_saturate: got %h expected %h", right_paddle_pos, {16'd608, 16'd380});
        end
        btn_r_up = 1'b1;
        for (int i = 0; i < 3; i++) ftick();
        btn_r_up = 1'b0;
        btn_r_dn = 1'b0;
        checks++;
        if (right_paddle_pos[15:0] !== 16'd380) begin
            errors++;
            $display("FAIL both_buttons: y=%0d expected 380", right_paddle_pos[15:0]);
        end
    endtask

    task automatic test_left_miss();
        player_did_score = 2'b10;
        frame_tick = 1'b1;
        btn_l_dn = 1'b1;
        cycle();
        frame_tick = 1'b0;
        btn_l_dn = 1'b0;
        checks++;
        if ({right_score, left_score, physics_rst_n} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL left_miss: r=%0d l=%0d prn=%b expected r=1 l=0 prn=0",
                     right_score, left_score, physics_rst_n);
        end
        checks++;
        if (left_paddle_pos[15:0] !== 16'd4) begin
            errors++;
            $display("FAIL tick_with_score: y=%0d expected 4", left_paddle_pos[15:0]);
        end
        for (int i = 0; i < 4; i++) cycle();
        player_did_score = 2'b00;
        checks++;
        if (right_score !== 4'd1) begin
            errors++;
            $display("FAIL sticky_ignored: r=%0d expected 1", right_score);
        end
    endtask

    task automatic test_win();
        serve_to_play();
        for (int i = 0; i < 7; i++) begin
            player_did_score = 2'b01;
            cycle();
            player_did_score = 2'b00;
            if (i < 6) serve_to_play();
        end
        checks++;
        if ({left_score, right_score, game_over, winner, physics_rst_n} !== {4'd7, 4'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL left_win: l=%0d r=%0d over=%b win=%b prn=%b expected 7 1 1 0 0",
                     left_score, right_score, game_over, winner, physics_rst_n);
        end
        btn_l_dn = 1'b1;
        ftick();
        btn_l_dn = 1'b0;
        checks++;
        if (left_paddle_pos[15:0] !== 16'd4) begin
            errors++;
            $display("FAIL over_frozen: y=%0d expected 4", left_paddle_pos[15:0]);
        end
        pulse_start();
        checks++;
        if ({left_score, right_score, game_over, physics_rst_n} !== {4'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart: l=%0d r=%0d over=%b prn=%b expected 0 0 0 0",
                     left_score, right_score, game_over, physics_rst_n);
        end
        checks++;
        if (left_paddle_pos[15:0] !== 16'd190) begin
            errors++;
            $display("FAIL restart_centre: y=%0d expected 190", left_paddle_pos[15:0]);
        end
    endtask

    task automatic test_tie();
        serve_to_play();
        player_did_score = 2'b11;
        cycle();
        player_did_score = 2'b00;
        checks++;
        if ({left_score, right_score, physics_rst_n, game_over} !== {4'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL tie: l=%0d r=%0d prn=%b over=%b expected 0 0 0 0",
                     left_score, right_score, physics_rst_n, game_over);
        end
    endtask

    task automatic test_right_win_and_reset();
        serve_to_play();
        for (int i = 0; i < 7; i++) begin
            player_did_score = 2'b10;
            cycle();
            player_did_score = 2'b00;
            if (i < 6) serve_to_play();
        end
        checks++;
        if ({right_score, game_over, winner} !== {4'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL right_win: r=%0d over=%b win=%b expected 7 1 1",
                     right_score, game_over, winner);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({left_score, right_score, game_over, winner, physics_rst_n} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: l=%0d r=%0d over=%b win=%b prn=%b expected all 0",
                     left_score, right_score, game_over, winner, physics_rst_n);
        end
    endtask

    initial begin
        test_reset();
        test_serve_countdown();
        test_paddle_up();
        test_paddle_down();
        test_left_miss();
        test_win();
        test_tie();
        test_right_win_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
